// File: rtl/sprite_pixel_gen.sv
// sprite_pixel_gen
// Pixel stage that sits after the VGA timing driver. It overlays one sprite,
// read from an external synchronous ROM, on a flat background. The output is
// registered 12-bit RGB plus hs/vs delayed to line up with the colour.
//
// Ports
//   vga_clk, rst_n        pixel clock; asynchronous active-low reset
//   h_cnt, v_cnt          raw counters from the timing driver
//   hs_in, vs_in          raw syncs from the timing driver
//   pos_x, pos_y          requested sprite top-left corner, visible coords
//   pos_valid, pos_ready  position handshake; a new position goes live at the next frame start
//   blink_en              hides the sprite while frame_cnt[4] is set
//   rom_addr, rom_data    sprite ROM port; data returns one cycle after the address
//   hs_out, vs_out        syncs delayed by three flops
//   rgb                   pixel colour {R4,G4,B4}
//   frame_tick            one-cycle pulse after the frame-start edge
module sprite_pixel_gen #(
    parameter int          H_START   = 144,
    parameter int          V_START   = 35,
    parameter int          H_ACTIVE  = 640,
    parameter int          V_ACTIVE  = 480,
    parameter int          SPR_W     = 32,
    parameter int          SPR_H     = 32,
    parameter int          ADDR_W    = 10,
    parameter logic [11:0] KEY_COLOR = 12'hF0F,
    parameter logic [11:0] BG_COLOR  = 12'h000
) (
    input  logic              vga_clk,
    input  logic              rst_n,
    input  logic [11:0]       h_cnt,
    input  logic [11:0]       v_cnt,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic [9:0]        pos_x,
    input  logic [8:0]        pos_y,
    input  logic              pos_valid,
    output logic              pos_ready,
    input  logic              blink_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [11:0]       rom_data,
    output logic              hs_out,
    output logic              vs_out,
    output logic [11:0]       rgb,
    output logic              frame_tick
);

    localparam int         SHIFT = $clog2(SPR_W);
    localparam logic [9:0] X_MAX = 10'(H_ACTIVE - SPR_W);
    localparam logic [8:0] Y_MAX = 9'(V_ACTIVE - SPR_H);

    // Keep the whole sprite on screen.
    function automatic logic [9:0] clamp_x(input logic [9:0] x);
        return (x > X_MAX) ? X_MAX : x;
    endfunction

    function automatic logic [8:0] clamp_y(input logic [8:0] y);
        return (y > Y_MAX) ? Y_MAX : y;
    endfunction

    function automatic logic [11:0] pick_colour(input logic        vis,
                                                input logic        ins,
                                                input logic [11:0] d,
                                                input logic        hide);
        if (!vis)
            return 12'h000;
        else if (ins && (d != KEY_COLOR) && !hide)
            return d;
        else
            return BG_COLOR;
    endfunction

    // Position state
    logic [9:0]        shadow_x_q, shadow_x_d, live_x_q, live_x_d;
    logic [8:0]        shadow_y_q, shadow_y_d, live_y_q, live_y_d;
    logic              pending_q, pending_d;
    logic [4:0]        frame_cnt_q, frame_cnt_d;
    logic              tick_q;

    // Pipeline registers
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              vis_p1_q, ins_p1_q, hs_p1_q, vs_p1_q;
    logic              vis_p2_q, ins_p2_q, hs_p2_q, vs_p2_q;
    logic [11:0]       rgb_q, rgb_d;
    logic              hs_out_q, vs_out_q;

    // Stage 1 decode: visibility, sprite hit and ROM address from raw counters.
    logic        fs, vis, ins;
    logic [10:0] x_pos, y_pos, lx, ly, dx, dy;

    assign fs    = (h_cnt == 12'd0) && (v_cnt == 12'd0);
    assign vis   = (h_cnt >= 12'(H_START)) && (h_cnt < 12'(H_START + H_ACTIVE)) &&
                   (v_cnt >= 12'(V_START)) && (v_cnt < 12'(V_START + V_ACTIVE));
    assign x_pos = h_cnt[10:0] - 11'(H_START);
    assign y_pos = v_cnt[10:0] - 11'(V_START);
    assign lx    = {1'b0, live_x_q};
    assign ly    = {2'b00, live_y_q};
    // 11 bits holds live+SPR_W without wrapping, so the upper bound compares cleanly.
    assign ins   = vis && (x_pos >= lx) && (x_pos < lx + 11'(SPR_W)) &&
                   (y_pos >= ly) && (y_pos < ly + 11'(SPR_H));
    assign dx    = x_pos - lx;
    assign dy    = y_pos - ly;

    always_comb begin
        shadow_x_d  = shadow_x_q;
        shadow_y_d  = shadow_y_q;
        live_x_d    = live_x_q;
        live_y_d    = live_y_q;
        pending_d   = pending_q;
        frame_cnt_d = frame_cnt_q;
        rom_addr_d  = '0;
        rgb_d       = pick_colour(vis_p2_q, ins_p2_q, rom_data, blink_en && frame_cnt_q[4]);

        if (ins)
            rom_addr_d = ADDR_W'((dy << SHIFT) | dx);

        // Commit only at frame start so a frame is never drawn with two positions.
        if (fs && pending_q) begin
            live_x_d  = shadow_x_q;
            live_y_d  = shadow_y_q;
            pending_d = 1'b0;
        end
        // pending_q=0 here, so an accept never collides with a commit.
        if (pos_valid && !pending_q) begin
            shadow_x_d = clamp_x(pos_x);
            shadow_y_d = clamp_y(pos_y);
            pending_d  = 1'b1;
        end
        if (fs)
            frame_cnt_d = frame_cnt_q + 5'd1;
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_x_q  <= '0;
            shadow_y_q  <= '0;
            live_x_q    <= '0;
            live_y_q    <= '0;
            pending_q   <= 1'b0;
            frame_cnt_q <= '0;
            tick_q      <= 1'b0;
            rom_addr_q  <= '0;
            vis_p1_q    <= 1'b0;
            ins_p1_q    <= 1'b0;
            hs_p1_q     <= 1'b1;
            vs_p1_q     <= 1'b1;
            vis_p2_q    <= 1'b0;
            ins_p2_q    <= 1'b0;
            hs_p2_q     <= 1'b1;
            vs_p2_q     <= 1'b1;
            rgb_q       <= '0;
            hs_out_q    <= 1'b1;
            vs_out_q    <= 1'b1;
        end else begin
            shadow_x_q  <= shadow_x_d;
            shadow_y_q  <= shadow_y_d;
            live_x_q    <= live_x_d;
            live_y_q    <= live_y_d;
            pending_q   <= pending_d;
            frame_cnt_q <= frame_cnt_d;
            tick_q      <= fs;
            // Stage 1: ROM address issued, flags captured
            rom_addr_q  <= rom_addr_d;
            vis_p1_q    <= vis;
            ins_p1_q    <= ins;
            hs_p1_q     <= hs_in;
            vs_p1_q     <= vs_in;
            // Stage 2: wait for the ROM read
            vis_p2_q    <= vis_p1_q;
            ins_p2_q    <= ins_p1_q;
            hs_p2_q     <= hs_p1_q;
            vs_p2_q     <= vs_p1_q;
            // Output stage: ROM data is valid now
            rgb_q       <= rgb_d;
            hs_out_q    <= hs_p2_q;
            vs_out_q    <= vs_p2_q;
        end
    end

    assign pos_ready  = !pending_q;
    assign rom_addr   = rom_addr_q;
    assign rgb        = rgb_q;
    assign hs_out     = hs_out_q;
    assign vs_out     = vs_out_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_sprite_pixel_gen.sv
// Bench for sprite_pixel_gen. It drives arbitrary counter sequences, because
// the block depends only on the counter values it sees. A behavioural model
// predicts every output on every cycle.
module tb_sprite_pixel_gen;

    logic        vga_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] h_cnt = 12'd0;
    logic [11:0] v_cnt = 12'd1;
    logic        hs_in = 1'b1;
    logic        vs_in = 1'b1;
    logic [9:0]  pos_x = 10'd0;
    logic [8:0]  pos_y = 9'd0;
    logic        pos_valid = 1'b0;
    logic        pos_ready;
    logic        blink_en = 1'b0;
    logic [9:0]  rom_addr;
    logic [11:0] rom_data = 12'd0;
    logic        hs_out, vs_out, frame_tick;
    logic [11:0] rgb;

    always #5 vga_clk = ~vga_clk;

    sprite_pixel_gen dut (
        .vga_clk(vga_clk), .rst_n(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .hs_in(hs_in), .vs_in(vs_in), .pos_x(pos_x), .pos_y(pos_y),
        .pos_valid(pos_valid), .pos_ready(pos_ready), .blink_en(blink_en),
        .rom_addr(rom_addr), .rom_data(rom_data), .hs_out(hs_out), .vs_out(vs_out),
        .rgb(rgb), .frame_tick(frame_tick)
    );

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // External sprite ROM
    int rom_mode = 0;
    function automatic logic [11:0] rom_f(input int a);
        if (rom_mode == 0)
            return (a == 5) ? 12'hF0F : 12'h0F0;
        return 12'(a * 7 + 1);
    endfunction

    always @(posedge vga_clk) rom_data <= rom_f(int'(rom_addr));

    // Behavioural model
    typedef struct {
        bit vis;
        bit ins;
        int addr;
        bit hs;
        bit vs;
    } pix_t;

    pix_t pq[$];
    int   m_live_x, m_live_y, m_sh_x, m_sh_y, m_fc;
    bit   m_pend;
    int   e_rgb = 0, e_addr = 0;
    bit   e_hs = 1, e_vs = 1, e_tick = 0, e_ready = 1;

    task automatic model_reset();
        pix_t p;
        p.vis = 0; p.ins = 0; p.addr = 0; p.hs = 1; p.vs = 1;
        pq.delete();
        pq.push_back(p);
        pq.push_back(p);
        m_live_x = 0; m_live_y = 0; m_sh_x = 0; m_sh_y = 0; m_fc = 0; m_pend = 0;
        e_rgb = 0; e_addr = 0; e_hs = 1; e_vs = 1; e_tick = 0; e_ready = 1;
    endtask

    task automatic model_step();
        int h, v, x, y, addr;
        bit fs, vis, ins, acc, com;
        pix_t p, e;
        logic [11:0] d;
        h = int'(h_cnt);
        v = int'(v_cnt);
        fs = (h == 0) && (v == 0);
        vis = (h >= 144) && (h < 784) && (v >= 35) && (v < 515);
        x = h - 144;
        y = v - 35;
        ins = vis && x >= m_live_x && x < m_live_x + 32 && y >= m_live_y && y < m_live_y + 32;
        addr = ins ? (y - m_live_y) * 32 + (x - m_live_x) : 0;
        p.vis = vis; p.ins = ins; p.addr = addr; p.hs = hs_in; p.vs = vs_in;
        pq.push_back(p);
        e = pq.pop_front();
        d = rom_f(e.addr);
        if (!e.vis)
            e_rgb = 0;
        else if (e.ins && d != 12'hF0F && !(blink_en && m_fc >= 16))
            e_rgb = int'(d);
        else
            e_rgb = 0;
        e_hs = e.hs;
        e_vs = e.vs;
        e_addr = addr;
        e_tick = fs;
        acc = pos_valid && !m_pend;
        com = fs && m_pend;
        if (com) begin
            m_live_x = m_sh_x;
            m_live_y = m_sh_y;
            m_pend = 0;
        end
        if (acc) begin
            m_sh_x = (int'(pos_x) > 608) ? 608 : int'(pos_x);
            m_sh_y = (int'(pos_y) > 448) ? 448 : int'(pos_y);
            m_pend = 1;
        end
        if (fs) m_fc = (m_fc + 1) % 32;
        e_ready = !m_pend;
    endtask

    always @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    // Per-cycle compare
    bit cmp_en = 0;
    int tick_cnt = 0;
    always @(negedge vga_clk) begin
        if (cmp_en) begin
            chk("rgb", int'(rgb), e_rgb);
            chk("rom_addr", int'(rom_addr), e_addr);
            chk("hs_out", int'(hs_out), int'(e_hs));
            chk("vs_out", int'(vs_out), int'(e_vs));
            chk("frame_tick", int'(frame_tick), int'(e_tick));
            chk("pos_ready", int'(pos_ready), int'(e_ready));
            if (frame_tick) tick_cnt++;
        end
    end

    // Position request driver
    bit wr_req = 0;
    bit rand_wr = 0;
    int wr_x = 0, wr_y = 0;
    always @(negedge vga_clk) begin
        if (wr_req) begin
            pos_valid = 1'b1;
            pos_x = 10'(wr_x);
            pos_y = 9'(wr_y);
        end else begin
            pos_valid = rand_wr && ($urandom_range(0, 49) == 0);
            pos_x = 10'($urandom_range(0, 1023));
            pos_y = 9'($urandom_range(0, 511));
        end
    end
    always @(posedge vga_clk) begin
        if (rst_n && wr_req && pos_valid && pos_ready) wr_req = 0;
    end

    task automatic step(input int h, input int v);
        @(negedge vga_clk);
        h_cnt = 12'(h);
        v_cnt = 12'(v);
        hs_in = 1'($urandom_range(0, 1));
        vs_in = 1'($urandom_range(0, 1));
    endtask

    task automatic pix_lit(input string name, input int h, input int v, input int a, input int c);
        step(h, v);
        @(posedge vga_clk); #1;
        chk({name, "_addr"}, int'(rom_addr), a);
        step(0, 1);
        step(0, 1);
        @(posedge vga_clk); #1;
        chk({name, "_rgb"}, int'(rgb), c);
    endtask

    task automatic scan(input int x0, input int y0);
        for (int v = 35 + y0 - 2; v <= 35 + y0 + 33; v++)
            for (int h = 144 + x0 - 2; h <= 144 + x0 + 33; h++)
                step(h, v);
    endtask

    task automatic write_pos(input string name, input int x, input int y);
        int i;
        wr_x = x;
        wr_y = y;
        wr_req = 1;
        i = 0;
        while (wr_req && i < 100) begin
            step(0, 1);
            i++;
        end
        if (wr_req) begin
            chk({name, "_accept_timeout"}, 1, 0);
            wr_req = 0;
        end else begin
            chk({name, "_ready_drop"}, int'(pos_ready), 0);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int fnum, r;
        repeat (3) @(posedge vga_clk);
        #1;
        cmp_en = 1;
        chk("rst_rgb", int'(rgb), 0);
        chk("rst_hs", int'(hs_out), 1);
        chk("rst_vs", int'(vs_out), 1);
        chk("rst_addr", int'(rom_addr), 0);
        chk("rst_tick", int'(frame_tick), 0);
        chk("rst_ready", int'(pos_ready), 1);
        @(posedge vga_clk); #2;
        rst_n = 1'b1;
        step(0, 1);
        step(0, 1);

        // Default position (0,0), key colour at address 5
        step(0, 0);
        @(posedge vga_clk); #1;
        chk("tick_lit", int'(frame_tick), 1);
        pix_lit("p0", 144, 35, 0, 12'h0F0);
        pix_lit("key", 149, 35, 5, 12'h000);
        pix_lit("nbr4", 148, 35, 4, 12'h0F0);
        pix_lit("nbr6", 150, 35, 6, 12'h0F0);
        pix_lit("corner", 175, 66, 1023, 12'h0F0);
        pix_lit("outside", 176, 35, 0, 12'h000);
        pix_lit("blank", 100, 20, 0, 12'h000);
        scan(0, 0);
        rom_mode = 1;

        // Mid-frame write: old position holds until frame start
        write_pos("w1", 100, 50);
        pix_lit("old", 144, 35, 0, 12'h001);
        step(0, 0);
        @(posedge vga_clk); #1;
        chk("ready_back", int'(pos_ready), 1);
        pix_lit("n_tl", 244, 85, 0, 12'h001);
        pix_lit("n_left", 243, 85, 0, 12'h000);
        pix_lit("n_br", 275, 116, 1023, 12'hBFA);
        pix_lit("n_right", 276, 116, 0, 12'h000);
        pix_lit("n_mid", 249, 87, 69, 12'h1E4);
        scan(100, 50);

        // Clamped position
        write_pos("w2", 700, 470);
        step(0, 0);
        pix_lit("c_last", 783, 514, 1023, 12'hBFA);
        pix_lit("c_first", 752, 483, 0, 12'h001);
        pix_lit("c_below", 783, 515, 0, 12'h000);
        scan(608, 448);

        // Reset in the middle of a sprite with a write pending
        write_pos("w3", 240, 10);
        step(0, 0);
        write_pos("w4", 50, 50);
        for (int h = 400; h < 404; h++) step(h, 50);
        @(posedge vga_clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rgb", int'(rgb), 0);
        chk("mid_rst_hs", int'(hs_out), 1);
        chk("mid_rst_vs", int'(vs_out), 1);
        chk("mid_rst_addr", int'(rom_addr), 0);
        chk("mid_rst_ready", int'(pos_ready), 1);
        repeat (2) @(posedge vga_clk);
        #2;
        rst_n = 1'b1;
        step(0, 0);
        pix_lit("rst_live", 144, 35, 0, 12'h001);
        fnum = 1;

        // Blink over 32 frames
        blink_en = 1'b1;
        tick_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            step(0, 0);
            fnum = (fnum + 1) % 32;
            pix_lit("blink", 145, 35, 1, (fnum >= 16) ? 0 : 12'h008);
        end
        step(0, 1);
        chk("tick_count", tick_cnt, 32);
        blink_en = 1'b0;

        // Random phase
        rand_wr = 1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) blink_en = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 99));
            if (r < 1)
                step(0, 0);
            else if (r < 40)
                step(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)));
            else
                step(142 + m_live_x + int'($urandom_range(0, 35)),
                     33 + m_live_y + int'($urandom_range(0, 35)));
        end
        rand_wr = 0;
        repeat (4) step(0, 1);
        cmp_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/sprite_pixel_gen.md
Name: sprite_pixel_gen

Overview:
- Pixel-generation stage directly downstream of the VGA timing driver.
- Consumes the raw h_cnt/v_cnt/hs/vs timing and overlays one 32x32 player-plane sprite, read from an external synchronous sprite ROM, on a flat background.
- Drives registered 12-bit RGB and delay-matched hs/vs to the VGA pins.
- Sprite position is written by game logic through a valid/ready handshake and applied only at frame boundaries, so the sprite never tears.

Parameters:
- H_START, 144, first visible h_cnt (sync+back porch)
- V_START, 35, first visible v_cnt
- H_ACTIVE, 640, visible columns
- V_ACTIVE, 480, visible rows
- SPR_W, 32, sprite width in pixels (power of 2)
- SPR_H, 32, sprite height in pixels
- ADDR_W, 10, sprite ROM address width (log2(SPR_W*SPR_H))
- KEY_COLOR, 12'hF0F, transparent colour in ROM data
- BG_COLOR, 12'h000, background colour

Ports:
- vga_clk  in  1  pixel clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- h_cnt  in  12  horizontal counter from timing driver (0..799)
- v_cnt  in  12  vertical counter from timing driver (0..524)
- hs_in  in  1  horizontal sync from timing driver
- vs_in  in  1  vertical sync from timing driver
- pos_x  in  10  requested sprite left edge, visible coords
- pos_y  in  9  requested sprite top edge, visible coords
- pos_valid  in  1  position request valid
- pos_ready  out  1  block can accept a position
- blink_en  in  1  enable sprite blink (invulnerability effect)
- rom_addr  out  ADDR_W  sprite ROM address, registered
- rom_data  in  12  sprite ROM data, valid 1 cycle after rom_addr
- hs_out  out  1  delayed hs
- vs_out  out  1  delayed vs
- rgb  out  12  pixel colour {R4,G4,B4}
- frame_tick  out  1  one-cycle pulse at frame start

Behaviour:
- Reset (rst_n low, async): rgb=0, hs_out=1, vs_out=1, rom_addr=0, frame_tick=0, pos_ready=1, shadow/live position=0, pending=0, frame_cnt=0, all pipeline flags=0.
- Frame start (fs): h_cnt==0 && v_cnt==0.

Position handshake:
- pos_ready = !pending.
- Accept on pos_valid && pos_ready: store clamped value in shadow and set pending.
  - x clamps to H_ACTIVE-SPR_W (608); y clamps to V_ACTIVE-SPR_H (448).
- At fs with pending=1: live <= shadow, pending <= 0.
- Accept in the fs cycle itself (pending was 0) goes to shadow only and commits at the next fs.
- pos_valid held with pos_ready=0 has no effect until ready.

Visibility and addressing:
- vis = H_START<=h_cnt<H_START+H_ACTIVE && V_START<=v_cnt<V_START+V_ACTIVE.
- x=h_cnt-H_START, y=v_cnt-V_START.
- ins = vis && x>=live_x && x<live_x+SPR_W && y>=live_y && y<live_y+SPR_H. Compare with 11-bit unsigned, no wrap.
- rom_addr <= ins ? (y-live_y)*SPR_W + (x-live_x) : 0. Shift, not multiply.

Pipeline (fixed, no stalls):
- Counters/hs_in/vs_in sampled at edge N: s1 at N, s2 at N+1, output regs at N+2.
- rom_addr registered at N; rom_data sampled at N+2.
- hs_out/vs_out are hs_in/vs_in delayed by exactly 3 flops.

Colour at output stage:
- !vis3 -> 12'h000 (blanking).
- vis3 && ins3 && rom_data!=KEY_COLOR && !(blink_en && frame_cnt[4]) -> rom_data.
- else -> BG_COLOR.

Frame counter and tick:
- 5-bit frame_cnt increments at fs, wraps 31->0; blink toggles every 16 frames.
- frame_tick=1 for exactly the cycle after the fs edge.

Reset mid-frame:
- Outputs return to reset values immediately.
- Counters resume from the driver; first valid colour appears 3 cycles after rst_n deassert.

Test Plan:
- Reset, run one frame, no position write -> sprite at (0,0): first ROM read rom_addr=0 for h_cnt=144,v_cnt=35; rgb=rom_data 3 cycles later; hs_out/vs_out match hs_in/vs_in delayed 3 cycles over the whole frame.
- Write pos (100,50) mid-frame -> pos_ready drops next cycle; old position used for rest of frame; new sprite spans h_cnt 244..275, v_cnt 85..116 next frame; pos_ready returns 1 after fs.
- Write pos (700,470) -> clamped to (608,448); rightmost sprite pixel at h_cnt=783, last row v_cnt=514, no ROM reads outside visible area.
- ROM returns 12'hF0F for address 5, 12'h0F0 elsewhere -> the pixel at sprite column 5 row 0 shows BG_COLOR, neighbours show 12'h0F0; pixels outside the visible area are 12'h000.
- blink_en=1 over 32 frames -> sprite hidden for frames 16..31, visible 0..15; frame_tick pulses exactly 32 times.
- Assert rst_n low at h_cnt=400 mid-sprite -> rgb=0, hs_out=1, rom_addr=0 asynchronously; pending write discarded, live position back to (0,0).
